// File: rtl/gtx_link_supervisor.sv
// Bring-up / recovery sequencer for an Aurora/GTX lane group, clocked on init_clk.
// Define LINK_SUP_STATS_EN to add the per-lane 16-bit lane-drop counters on drop_cnt.
module gtx_link_supervisor #(
   parameter int                   NUM_LANES       = 4,
   parameter logic [NUM_LANES-1:0] LANE_MASK       = 4'b0011,
   parameter int                   RST_PULSE       = 1000,
   parameter int                   UP_TIMEOUT      = 65535,
   parameter int                   DEBOUNCE        = 16,
   parameter int                   FIFO_RST_CYCLES = 8,
   parameter int                   MAX_RETRY       = 3
) (
   input  logic                 init_clk,
   input  logic                 init_rst_n,
   input  logic [NUM_LANES-1:0] gtp_up,
   input  logic                 retry_req,
   output logic                 gtp_reset,
   output logic [NUM_LANES-1:0] gtp_fifo_rst,
   output logic [NUM_LANES-1:0] lane_ok,
   output logic                 link_ok,
   output logic                 link_fail,
   output logic [1:0]           retry_cnt,
   output logic [2:0]           sup_state
`ifdef LINK_SUP_STATS_EN
   ,
   output logic [NUM_LANES*16-1:0] drop_cnt
`endif
);

   localparam int TMAX0 = (RST_PULSE > UP_TIMEOUT) ? RST_PULSE : UP_TIMEOUT;
   localparam int TMAX  = (TMAX0 > FIFO_RST_CYCLES) ? TMAX0 : FIFO_RST_CYCLES;
   localparam int TW    = $clog2(TMAX + 1);
   localparam int FW    = $clog2(FIFO_RST_CYCLES + 1);
   localparam int DW    = $clog2(DEBOUNCE + 1);

   typedef enum logic [2:0] {
      S_RESET   = 3'd0,
      S_WAIT_UP = 3'd1,
      S_FLUSH   = 3'd2,
      S_RUN     = 3'd3,
      S_FAIL    = 3'd4
   } state_t;

   state_t               state_reg;
   logic [TW-1:0]        timer_reg;
   logic [NUM_LANES-1:0] sync1_reg;
   logic [NUM_LANES-1:0] sync2_reg;
   logic [NUM_LANES-1:0] up_db;
   logic [NUM_LANES-1:0] drop_evt;
   logic [NUM_LANES-1:0] rec_done;
   logic [NUM_LANES-1:0] rec_to;
   logic [NUM_LANES-1:0] lane_ok_next;
   logic [1:0]           retry_inc;
   logic                 retry_exhausted;
   logic                 all_up;
   logic                 attempt_fail;

   assign sup_state = state_reg;

   always_ff @(posedge init_clk or negedge init_rst_n) begin
      if (!init_rst_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= gtp_up;
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         logic [DW-1:0] db_cnt_reg;
         logic [TW-1:0] rec_timer_reg;
         logic [FW-1:0] flush_cnt_reg;
         logic          recovering_reg;

         always_ff @(posedge init_clk or negedge init_rst_n) begin
            if (!init_rst_n) begin
               db_cnt_reg <= '0;
            end else if (!sync2_reg[gi]) begin
               db_cnt_reg <= '0;
            end else if (db_cnt_reg != DW'(DEBOUNCE)) begin
               db_cnt_reg <= db_cnt_reg + 1'b1;
            end
         end

         assign up_db[gi]    = (db_cnt_reg == DW'(DEBOUNCE));
         // Drops act on the raw synced bit; only recovery is debounced.
         assign drop_evt[gi] = LANE_MASK[gi] && (state_reg == S_RUN) && lane_ok[gi] && !sync2_reg[gi];
         assign rec_done[gi] = recovering_reg && up_db[gi] &&
                               (flush_cnt_reg == FW'(FIFO_RST_CYCLES - 1));
         assign rec_to[gi]   = recovering_reg && (rec_timer_reg == TW'(UP_TIMEOUT - 1));

         always_ff @(posedge init_clk or negedge init_rst_n) begin
            if (!init_rst_n) begin
               recovering_reg <= 1'b0;
               rec_timer_reg  <= '0;
               flush_cnt_reg  <= '0;
            end else if (state_reg != S_RUN) begin
               recovering_reg <= 1'b0;
               rec_timer_reg  <= '0;
               flush_cnt_reg  <= '0;
            end else if (drop_evt[gi]) begin
               recovering_reg <= 1'b1;
               rec_timer_reg  <= '0;
               flush_cnt_reg  <= '0;
            end else if (recovering_reg) begin
               recovering_reg <= !rec_done[gi];
               rec_timer_reg  <= rec_timer_reg + 1'b1;
               flush_cnt_reg  <= up_db[gi] ? flush_cnt_reg + 1'b1 : '0;
            end
         end

`ifdef LINK_SUP_STATS_EN
         logic [15:0] drop_cnt_reg;

         always_ff @(posedge init_clk or negedge init_rst_n) begin
            if (!init_rst_n) begin
               drop_cnt_reg <= '0;
            end else if (drop_evt[gi] && !(|rec_to) && (drop_cnt_reg != 16'hFFFF)) begin
               drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
         end

         assign drop_cnt[gi*16 +: 16] = drop_cnt_reg;
`else
         // No per-lane drop statistics in this build.
`endif
      end
   endgenerate

   assign all_up          = ((up_db & LANE_MASK) == LANE_MASK);
   assign retry_inc       = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
   assign retry_exhausted = ({30'd0, retry_inc} >= MAX_RETRY);
   assign lane_ok_next    = (lane_ok & ~drop_evt) | rec_done;
   // A bring-up attempt fails on wait timeout (success has priority) or any lane recovery timeout.
   assign attempt_fail    = ((state_reg == S_WAIT_UP) && !all_up && (timer_reg == TW'(UP_TIMEOUT - 1))) ||
                            ((state_reg == S_RUN) && (|rec_to));

   always_ff @(posedge init_clk or negedge init_rst_n) begin
      if (!init_rst_n) begin
         state_reg    <= S_RESET;
         timer_reg    <= '0;
         gtp_reset    <= 1'b1;
         gtp_fifo_rst <= '1;
         lane_ok      <= '0;
         link_ok      <= 1'b0;
         link_fail    <= 1'b0;
         retry_cnt    <= 2'd0;
      end else if (attempt_fail) begin
         state_reg    <= retry_exhausted ? S_FAIL : S_RESET;
         retry_cnt    <= retry_inc;
         link_fail    <= retry_exhausted;
         timer_reg    <= '0;
         gtp_reset    <= 1'b1;
         gtp_fifo_rst <= '1;
         lane_ok      <= '0;
         link_ok      <= 1'b0;
      end else begin
         case (state_reg)
            S_RESET: begin
               if (timer_reg == TW'(RST_PULSE - 1)) begin
                  state_reg <= S_WAIT_UP;
                  timer_reg <= '0;
                  gtp_reset <= 1'b0;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            S_WAIT_UP: begin
               if (all_up) begin
                  state_reg <= S_FLUSH;
                  timer_reg <= '0;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            S_FLUSH: begin
               if (timer_reg == TW'(FIFO_RST_CYCLES - 1)) begin
                  state_reg    <= S_RUN;
                  gtp_fifo_rst <= ~LANE_MASK;
                  lane_ok      <= LANE_MASK;
                  link_ok      <= 1'b1;
                  retry_cnt    <= 2'd0;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            S_RUN: begin
               lane_ok      <= lane_ok_next;
               gtp_fifo_rst <= (gtp_fifo_rst | drop_evt) & ~rec_done;
               link_ok      <= ((lane_ok_next & LANE_MASK) == LANE_MASK);
            end
            S_FAIL: begin
               if (retry_req) begin
                  state_reg <= S_RESET;
                  retry_cnt <= 2'd0;
                  link_fail <= 1'b0;
                  timer_reg <= '0;
               end
            end
            default: begin
               state_reg    <= S_RESET;
               timer_reg    <= '0;
               gtp_reset    <= 1'b1;
               gtp_fifo_rst <= '1;
               lane_ok      <= '0;
               link_ok      <= 1'b0;
               link_fail    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gtx_link_supervisor.sv
// Randomized self-checking bench for gtx_link_supervisor against a cycle-level rule model.
// Define LINK_SUP_STATS_EN to also check drop_cnt.
module tb_gtx_link_supervisor;

   localparam int         NL    = 4;
   localparam logic [3:0] MASK  = 4'b0011;
   localparam int         RSTP  = 16;
   localparam int         TOUT  = 64;
   localparam int         DB    = 4;
   localparam int         FRC   = 8;
   localparam int         MAXR  = 3;
   localparam logic [15:0] RST_VEC = {1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0};

   logic        clk;
   logic        init_rst_n;
   logic [3:0]  gtp_up;
   logic        retry_req;
   logic        gtp_reset;
   logic [3:0]  gtp_fifo_rst;
   logic [3:0]  lane_ok;
   logic        link_ok;
   logic        link_fail;
   logic [1:0]  retry_cnt;
   logic [2:0]  sup_state;
`ifdef LINK_SUP_STATS_EN
   logic [63:0] drop_cnt;
`endif

   gtx_link_supervisor #(
      .NUM_LANES(NL), .LANE_MASK(MASK), .RST_PULSE(RSTP), .UP_TIMEOUT(TOUT),
      .DEBOUNCE(DB), .FIFO_RST_CYCLES(FRC), .MAX_RETRY(MAXR)
   ) dut (
      .init_clk(clk), .init_rst_n(init_rst_n), .gtp_up(gtp_up), .retry_req(retry_req),
      .gtp_reset(gtp_reset), .gtp_fifo_rst(gtp_fifo_rst), .lane_ok(lane_ok),
      .link_ok(link_ok), .link_fail(link_fail), .retry_cnt(retry_cnt), .sup_state(sup_state)
`ifdef LINK_SUP_STATS_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: state numbers 0..4 are the documented sup_state codes.
   int         ms, mt, mr;
   bit         mg, ml, mf;
   logic [3:0] mok, mfifo;
   bit         rec [NL];
   int         rt [NL];
   int         fc [NL];
   int         mdrop [NL];
   logic [3:0] hq [$];     // hq[0] = gtp_up sampled at the latest edge

   function automatic void model_reset();
      ms = 0; mt = 0; mr = 0; mg = 1'b1; ml = 1'b0; mf = 1'b0;
      mok = 4'h0; mfifo = 4'hF;
      for (int i = 0; i < NL; i++) begin
         rec[i] = 1'b0; rt[i] = 0; fc[i] = 0; mdrop[i] = 0;
      end
      hq.delete();
      for (int k = 0; k < DB + 3; k++) hq.push_back(4'h0);
   endfunction

   function automatic void attempt_failed();
      mr = (mr < 3) ? mr + 1 : 3;
      ms = (mr >= MAXR) ? 4 : 0;
      mf = (mr >= MAXR);
      mt = 0; mg = 1'b1; mfifo = 4'hF; mok = 4'h0; ml = 1'b0;
      for (int i = 0; i < NL; i++) begin
         rec[i] = 1'b0; rt[i] = 0; fc[i] = 0;
      end
   endfunction

   function automatic void model_edge();
      logic [3:0] s2;
      logic [3:0] db;
      bit         timeout;
      if (!init_rst_n) begin
         model_reset();
         return;
      end
      // Synced bit lags 2 edges; debounced-up means the last DB synced samples were all 1.
      s2 = hq[1];
      db = 4'hF;
      for (int k = 2; k < DB + 2; k++) db = db & hq[k];
      hq.push_front(gtp_up);
      void'(hq.pop_back());
      case (ms)
         0: if (mt == RSTP - 1) begin ms = 1; mt = 0; mg = 1'b0; end else mt++;
         1: begin
            if ((db & MASK) == MASK) begin ms = 2; mt = 0; end
            else if (mt == TOUT - 1) attempt_failed();
            else mt++;
         end
         2: begin
            if (mt == FRC - 1) begin
               ms = 3; mfifo = ~MASK; mok = MASK; ml = 1'b1; mr = 0;
            end else mt++;
         end
         3: begin
            timeout = 1'b0;
            for (int i = 0; i < NL; i++)
               if (MASK[i] && rec[i] && rt[i] == TOUT - 1) timeout = 1'b1;
            if (timeout) attempt_failed();
            else begin
               for (int i = 0; i < NL; i++) begin
                  if (!MASK[i]) continue;
                  if (mok[i] && !s2[i]) begin
                     mok[i] = 1'b0; mfifo[i] = 1'b1; rec[i] = 1'b1; rt[i] = 0; fc[i] = 0;
                     if (mdrop[i] < 65535) mdrop[i]++;
                  end else if (rec[i]) begin
                     rt[i]++;
                     if (db[i]) begin
                        if (fc[i] == FRC - 1) begin
                           rec[i] = 1'b0; mok[i] = 1'b1; mfifo[i] = 1'b0;
                        end else fc[i]++;
                     end else fc[i] = 0;
                  end
               end
               ml = ((mok & MASK) == MASK);
            end
         end
         default: if (retry_req) begin ms = 0; mr = 0; mf = 1'b0; mt = 0; end
      endcase
   endfunction

   function automatic logic [15:0] actual_vec();
      return {gtp_reset, gtp_fifo_rst, lane_ok, link_ok, link_fail, retry_cnt, sup_state};
   endfunction

   function automatic logic [15:0] expected_vec();
      return {mg, mfifo, mok, ml, mf, 2'(mr), 3'(ms)};
   endfunction

   bit reset_seen, flush_seen;
   int n;

   task automatic step();
      logic [63:0] exp_drop;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_value("outs", 64'(actual_vec()), 64'(expected_vec()));
`ifdef LINK_SUP_STATS_EN
      exp_drop = '0;
      for (int i = 0; i < NL; i++) exp_drop[i*16 +: 16] = 16'(mdrop[i]);
      check_value("drop_cnt", drop_cnt, exp_drop);
`else
      exp_drop = '0;
`endif
      if (gtp_reset) reset_seen = 1'b1;
      if (sup_state == 3'd2) flush_seen = 1'b1;
      gtp_up[3:2] = 2'($urandom_range(0, 3));   // unmasked lanes toggle freely
   endtask

   task automatic wait_state(input logic [2:0] st, input int bound);
      n = 0;
      while (sup_state != st && n < bound) begin step(); n++; end
      check_value("wait_state", 64'(sup_state), 64'(st));
   endtask

   task automatic drop_lane1(input int len);
      gtp_up[1] = 1'b0;
      n = 0;
      while (link_ok && n < 10) begin step(); n++; end
      check_value("drop_lat_ok", 64'(n <= 3), 64'd1);
      check_value("drop_lane_ok", 64'(lane_ok), 64'h1);
      while (n < len) begin step(); n++; end
      gtp_up[1] = 1'b1;
      n = 0;
      while (gtp_fifo_rst[1] && n < 100) begin step(); n++; end
      check_value("fifo_rel_lat", 64'(n), 64'(2 + DB + FRC));
      check_value("relink", 64'(link_ok), 64'd1);
   endtask

   initial begin
      init_rst_n = 1'b0; gtp_up = 4'h0; retry_req = 1'b0;
      model_reset();
      repeat (3) step();
      check_value("reset_vals", 64'(actual_vec()), 64'(RST_VEC));

      // 1: bring-up
      init_rst_n = 1'b1;
      n = 0;
      while (gtp_reset && n < 100) begin
         if (n >= 4) gtp_up[1:0] = 2'b11;
         step(); n++;
      end
      check_value("rst_pulse_len", 64'(n), 64'(RSTP));
      n = 0;
      while (!link_ok && n < 100) begin step(); n++; end
      check_value("linkup_lat_ok", 64'(n <= 2 + DB + FRC + 2), 64'd1);
      check_value("run_fifo_rst", 64'(gtp_fifo_rst), 64'hC);
      check_value("run_state", 64'(sup_state), 64'd3);
      $display("scenario 1 bring-up: link_ok after %0d cycles in wait", n);

      // 3: lane 1 drop and recovery
      reset_seen = 1'b0;
      drop_lane1(20);
      check_value("no_gt_reset", 64'(reset_seen), 64'd0);
      $display("scenario 3 lane-1 drop/recover done");

      // 4: lane 0 lost permanently
      gtp_up[0] = 1'b0;
      n = 0;
      while (sup_state != 3'd0 && n < 200) begin step(); n++; end
      check_value("rec_timeout_lat", 64'(n), 64'(2 + 1 + TOUT));
      check_value("retry_after_to", 64'(retry_cnt), 64'd1);
      $display("scenario 4 recovery timeout after %0d cycles", n);

      // 5: short glitch on lane 0 during wait must not start flush
      gtp_up[1] = 1'b1;
      wait_state(3'd1, 100);
      flush_seen = 1'b0;
      gtp_up[0] = 1'b1;
      repeat (3) step();
      gtp_up[0] = 1'b0;
      repeat (30) step();
      check_value("no_flush_on_glitch", 64'(flush_seen), 64'd0);
      $display("scenario 5 glitch rejected");

      // 2: no lanes ever up -> fail after three attempts
      init_rst_n = 1'b0;
      repeat (2) step();
      init_rst_n = 1'b1;
      gtp_up[1:0] = 2'b00;
      n = 0;
      while (!link_fail && n < 1000) begin step(); n++; end
      check_value("fail_lat", 64'(n), 64'(MAXR * (RSTP + TOUT)));
      check_value("fail_retry", 64'(retry_cnt), 64'd3);
      check_value("fail_gt_reset", 64'(gtp_reset), 64'd1);
      repeat (5) step();
      retry_req = 1'b1;
      step();
      retry_req = 1'b0;
      check_value("retry_state", 64'(sup_state), 64'd0);
      check_value("retry_clr", 64'(retry_cnt), 64'd0);
      $display("scenario 2 fail and retry_req restart");

      // 6: async reset during flush
      gtp_up[1:0] = 2'b11;
      wait_state(3'd2, 200);
      step();
      #2 init_rst_n = 1'b0;
      #1 check_value("async_rst", 64'(actual_vec()), 64'(RST_VEC));
      model_reset();
      repeat (2) step();
      init_rst_n = 1'b1;
      wait_state(3'd3, 200);
      drop_lane1(20);
      drop_lane1(15);
`ifdef LINK_SUP_STATS_EN
      check_value("drop_cnt_lane1", 64'(drop_cnt[31:16]), 64'd2);
`endif
      $display("scenario 6 async reset and repeated drops");

      // random phase
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 29) == 0) gtp_up[0] = ~gtp_up[0];
         if ($urandom_range(0, 29) == 0) gtp_up[1] = ~gtp_up[1];
         retry_req = ($urandom_range(0, 39) == 0);
         step();
      end
      retry_req = 1'b0;
      $display("random phase done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
